// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes, command classes and FSM states shared by the LCD bus responder.
package lcd_pkg;
  localparam logic [7:0] MODE_SET = 8'h31;
  localparam logic [7:0] CURSOR_SET = 8'h0C;
  localparam logic [7:0] ADDRESS_SET = 8'h06;
  localparam logic [7:0] CLEAR_SET = 8'h01;
  localparam logic [7:0] DDRAM_BASE = 8'h80;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [3:0] {
    CMD_NOP, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPLAY,
    CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
  } cmd_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;
  // The highest set bit of a command byte selects its class.
  function automatic cmd_e classify(input logic [7:0] d);
    return (d & DDRAM_BASE) != 8'h00 ? CMD_DDRAM :
           d[6] ? CMD_CGRAM : d[5] ? CMD_FUNC : d[4] ? CMD_SHIFT :
           d[3] ? CMD_DISPLAY : d[2] ? CMD_ENTRY : d[1] ? CMD_HOME :
           d == CLEAR_SET ? CMD_CLEAR : CMD_NOP;
  endfunction
endpackage

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: registers the LCD bus and flags the falling edge of en as a one-cycle strobe.
module lcd_strobe_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] data,
  output logic       stb,
  output logic       rs_q,
  output logic       rw_q,
  output logic [7:0] data_q
);
  logic en_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rs_q, rw_q, en_q, data_q} <= '0;
    else {rs_q, rw_q, en_q, data_q} <= {rs, rw, en, data};
  assign stb = en_q & ~en;
endmodule

// File: rtl/lcd_text_responder.sv
// lcd_text_responder: character-LCD bus responder with DDRAM shadow and read-back port.
// Define LCD_PROTO_CHECK_EN to add the sticky proto_err output for dropped/read strobes.
module lcd_text_responder
  import lcd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int SHORT_BUSY_CYC = 1850,
  parameter int LONG_BUSY_CYC = 76000,
  localparam int IDX_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lcd_rs,
  input  logic             lcd_rw,
  input  logic             lcd_en,
  input  logic [7:0]       lcd_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_char,
  output logic [IDX_W-1:0] cursor,
  output logic [IDX_W-1:0] shift_ofs,
  output logic             display_on,
  output logic             cursor_on,
  output logic             blink_on,
  output logic             entry_inc,
  output logic             entry_shift,
  output logic [2:0]       func,
  output logic             busy
`ifdef LCD_PROTO_CHECK_EN
  , output logic           proto_err
`endif
);
  localparam int CNT_W = $clog2(LONG_BUSY_CYC + 1);
  logic stb, rs_q, rw_q, accept;
  logic [7:0] data_q;
  logic [7:0] ddram [COLS];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] step, mv, rd_addr, fill_idx;
  state_e state;
  cmd_e cmd;
  lcd_strobe_sync u_sync (
    .clk(clk), .rst_n(rst_n), .rs(lcd_rs), .rw(lcd_rw), .en(lcd_en), .data(lcd_data),
    .stb(stb), .rs_q(rs_q), .rw_q(rw_q), .data_q(data_q)
  );
  assign cmd = classify(data_q);
  assign step = entry_inc ? IDX_W'(1) : '1;
  assign mv = data_q[2] ? IDX_W'(1) : '1;
  assign rd_addr = rd_idx + shift_ofs;
  // The clear fill walks the cells in lockstep with the first COLS busy counts.
  assign fill_idx = IDX_W'(CNT_W'(LONG_BUSY_CYC) - cnt);
  assign accept = stb && state == ST_IDLE && !rw_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      ddram <= '{default: ASCII_SPACE};
      rd_char <= ASCII_SPACE;
      cursor <= '0;
      shift_ofs <= '0;
      {display_on, cursor_on, blink_on} <= 3'b000;
      {entry_inc, entry_shift} <= 2'b10;
      func <= 3'b100;
      busy <= 1'b0;
    end else begin
      rd_char <= ddram[rd_addr];
      if (state != ST_IDLE) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
      end
      if (state == ST_CLEAR && cnt > CNT_W'(LONG_BUSY_CYC - COLS)) begin
        ddram[fill_idx] <= ASCII_SPACE;
        if (fill_idx == IDX_W'(COLS - 1)) begin
          cursor <= '0;
          shift_ofs <= '0;
          entry_inc <= 1'b1;
        end
      end
      if (accept) begin
        busy <= 1'b1;
        state <= (!rs_q && cmd == CMD_CLEAR) ? ST_CLEAR : ST_EXEC;
        cnt <= (!rs_q && (cmd == CMD_CLEAR || cmd == CMD_HOME)) ? CNT_W'(LONG_BUSY_CYC)
                                                                : CNT_W'(SHORT_BUSY_CYC);
        if (rs_q) begin
          ddram[cursor] <= data_q;
          cursor <= cursor + step;
          if (entry_shift) shift_ofs <= shift_ofs + step;
        end else
          case (cmd)
            CMD_DDRAM: cursor <= data_q[IDX_W-1:0];
            CMD_FUNC: func <= data_q[4:2];
            CMD_SHIFT: if (data_q[3]) shift_ofs <= shift_ofs + mv; else cursor <= cursor + mv;
            CMD_DISPLAY: {display_on, cursor_on, blink_on} <= data_q[2:0];
            CMD_ENTRY: {entry_inc, entry_shift} <= data_q[1:0];
            CMD_HOME: begin
              cursor <= '0;
              shift_ofs <= '0;
            end
            default: ;
          endcase
      end
    end
`ifdef LCD_PROTO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) proto_err <= 1'b0;
    else if (stb && (state != ST_IDLE || rw_q)) proto_err <= 1'b1;
`endif
endmodule
